// File: rtl/hidden_relu_serializer.sv
// -----------------------------------------------------------------------------
// hidden_relu_serializer
//   Captures one hidden-layer dot-product vector (HID_LENGTH signed lanes),
//   applies ReLU followed by a logical right shift to every lane, and streams
//   the result downstream as HID_LENGTH/DATA_N chunks of DATA_N lanes each
//   over a valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   run        : synchronous enable; low flushes back to IDLE and blocks capture
//   in_valid   : upstream dot stage has a complete result on in_data
//   in_data    : HID_LENGTH signed lanes, lane i at [BIT_LENGTH*i +: BIT_LENGTH]
//   in_ready   : block can capture this cycle (IDLE and run)
//   out_valid  : out_data holds a valid chunk (state SEND)
//   out_ready  : downstream accepts the current chunk
//   out_data   : current chunk, lowest lane of the chunk at the LSBs
//   out_idx    : current chunk index
//   out_last   : out_valid on the final chunk
//   err_drop   : sticky, set when an input vector arrives while busy
// -----------------------------------------------------------------------------
module hidden_relu_serializer #(
    parameter int unsigned BIT_LENGTH = 16,
    parameter int unsigned HID_LENGTH = 24,
    parameter int unsigned DATA_N     = 6,
    parameter int unsigned SHIFT      = 0,
    localparam int unsigned N_CHUNKS  = HID_LENGTH / DATA_N,
    localparam int unsigned IDX_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             run,
    input  logic                             in_valid,
    input  logic [HID_LENGTH*BIT_LENGTH-1:0] in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_N*BIT_LENGTH-1:0]     out_data,
    output logic [IDX_W-1:0]                 out_idx,
    output logic                             out_last,
    output logic                             err_drop
);

    localparam int unsigned HID_W   = HID_LENGTH * BIT_LENGTH;
    localparam int unsigned CHUNK_W = DATA_N * BIT_LENGTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic [HID_W-1:0]   r_hid;
    logic [HID_W-1:0]   w_relu;
    logic [CHUNK_W-1:0] w_chunk;
    logic               r_err;
    logic               w_idle;
    logic               w_send;
    logic               w_last_chunk;
    logic               w_capture;
    logic               w_drop;

    assign w_idle       = (r_state == S_IDLE);
    assign w_send       = (r_state == S_SEND);
    assign w_last_chunk = (r_cnt == IDX_W'(N_CHUNKS - 1));

    // rst_n is folded in so in_ready stays low throughout reset even if run is high.
    assign in_ready  = rst_n & run & w_idle;
    assign w_capture = in_ready & in_valid;
    // A vector offered while busy is lost; run low is a flush, not a loss.
    assign w_drop    = run & in_valid & w_send;

    // Per-lane ReLU then logical right shift; result never exceeds the lane width.
    for (genvar g = 0; g < HID_LENGTH; g++) begin : g_lane
        logic [BIT_LENGTH-1:0] w_lane;
        assign w_lane = in_data[g*BIT_LENGTH +: BIT_LENGTH];
        assign w_relu[g*BIT_LENGTH +: BIT_LENGTH] =
            w_lane[BIT_LENGTH-1] ? {BIT_LENGTH{1'b0}} : (w_lane >> SHIFT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and chunk counter; run low dominates every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!run) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_state_nxt = S_SEND;
                        w_cnt_nxt   = '0;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (w_last_chunk) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Captured, already-transformed lanes; only rewritten on an accepted capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hid <= '0;
        end else if (w_capture) begin
            r_hid <= w_relu;
        end
    end

    // Sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

    // Chunk select from registered lanes and counter, so it holds while stalled.
    always_comb begin
        w_chunk = '0;
        for (int k = 0; k < int'(N_CHUNKS); k++) begin
            if (r_cnt == IDX_W'(k)) begin
                w_chunk = r_hid[k*CHUNK_W +: CHUNK_W];
            end
        end
    end

    assign out_valid = w_send;
    assign out_data  = w_chunk;
    assign out_idx   = r_cnt;
    assign out_last  = w_send & w_last_chunk;
    assign err_drop  = r_err;

endmodule

// File: doc/hidden_relu_serializer.md
HIDDEN_RELU_SERIALIZER -- requirements
Module: hidden_relu_serializer

Interface
REQ-001 Parameter BIT_LENGTH, default 16, SHALL set the bit width of one lane.
REQ-002 Parameter HID_LENGTH, default 24, SHALL set the number of lanes in the captured hidden vector.
REQ-003 Parameter DATA_N, default 6, SHALL set the number of lanes per output chunk; HID_LENGTH SHALL be a multiple of DATA_N.
REQ-004 Parameter SHIFT, default 0, SHALL set the right-shift amount applied after ReLU.
REQ-005 The clock port SHALL be clk, input, 1 bit; it is the only clock and all state updates on its rising edge.
REQ-006 The reset port SHALL be rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 Port run SHALL be an input, 1 bit; it is the synchronous enable, and low means flush.
REQ-008 Port in_valid SHALL be an input, 1 bit; high means in_data holds a complete dot-product result, and it connects to the upstream dot stage's valid.
REQ-009 Port in_data SHALL be an input, HID_LENGTH*BIT_LENGTH bits, carrying signed two's-complement lanes, with lane i at bits [BIT_LENGTH*i+BIT_LENGTH-1 : BIT_LENGTH*i].
REQ-010 Port in_ready SHALL be an output, 1 bit; high means the block can capture this cycle.
REQ-011 Port out_valid SHALL be an output, 1 bit; high means out_data holds a valid chunk.
REQ-012 Port out_ready SHALL be an input, 1 bit; it is downstream acceptance.
REQ-013 Port out_data SHALL be an output, DATA_N*BIT_LENGTH bits, carrying the current chunk with lane 0 at the LSBs.
REQ-014 Port out_idx SHALL be an output, clog2(HID_LENGTH/DATA_N) bits, giving the current chunk index.
REQ-015 Port out_last SHALL be an output, 1 bit; high with out_valid on the final chunk.
REQ-016 Port err_drop SHALL be an output, 1 bit; it is a sticky flag set when a result is lost.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-018 in_ready SHALL be high if and only if state is IDLE and run is high (registered state, no combinational path from out_ready).
REQ-019 In IDLE, when run and in_valid are both high, the block SHALL capture all HID_LENGTH lanes, set the chunk counter to 0, and enter SEND on the next edge.
REQ-020 Per-lane transform at capture: negative values (MSB 1) SHALL become 0; otherwise the value SHALL be logically right-shifted by SHIFT; results SHALL stay BIT_LENGTH wide with no saturation needed.
REQ-021 out_valid SHALL be high exactly when state is SEND; the first chunk SHALL appear the cycle after capture (latency 1).
REQ-022 Chunk k SHALL carry transformed lanes DATA_N*k to DATA_N*k+DATA_N-1, with lane DATA_N*k at the LSBs; out_idx SHALL equal k.
REQ-023 out_data and out_idx SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 On out_valid and out_ready both high with k below the last index, the counter SHALL increment.
REQ-025 On out_valid and out_ready both high with k at the last index, the state SHALL return to IDLE; in_ready SHALL be high the following cycle, giving one bubble cycle between vectors.
REQ-026 out_last SHALL equal out_valid AND (k equals HID_LENGTH/DATA_N-1).
REQ-027 in_valid high while in_ready is low and run is high (including the cycle of the final handshake) SHALL discard the input, set err_drop, and leave the captured data unchanged.
REQ-028 run low SHALL synchronously force IDLE and counter 0, drop out_valid on the next edge, and block capture; err_drop SHALL be preserved.
REQ-029 err_drop SHALL clear only on reset.

Reset
REQ-030 While rst_n is low, the state SHALL be IDLE and the counter SHALL be 0.
REQ-031 While rst_n is low, out_valid, out_last and err_drop SHALL be 0.
REQ-032 While rst_n is low, out_data and out_idx SHALL be 0, and the captured lane registers SHALL be 0.
REQ-033 in_ready SHALL be 0 while rst_n is low.
REQ-034 Reset asserted mid-SEND SHALL abort the transfer immediately, asynchronously.

Verification
REQ-035 Basic: run=1, in_valid pulse with lane i = i+1, out_ready=1 -> out_valid 4 consecutive cycles; chunk 0 = 1..6, chunk 3 = 19..24; out_last only on out_idx=3; in_ready returns after 1 bubble cycle.
REQ-036 ReLU/shift: SHIFT=2, lanes {-5, 0x7FFF, 7, 0x8000, ...} -> outputs {0, 0x1FFF, 1, 0}.
REQ-037 Backpressure: out_ready toggled 0,0,1,0,1,1,0,1 -> each chunk delivered exactly once, in order, stable while stalled.
REQ-038 Overrun: second in_valid during SEND chunk 1, and a third on the final handshake cycle -> both dropped, err_drop=1 sticky, first vector output intact.
REQ-039 Flush: run deasserted at chunk 2 -> out_valid 0 next cycle, in_ready 0 until run=1, next vector starts at out_idx 0.
REQ-040 Async reset: rst_n low mid-SEND, between clock edges -> all outputs 0 immediately, err_drop cleared.
